// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the LEGv8 core. It holds the program counter and requests one
// instruction word at a time from instruction memory using a req/ready
// handshake. It then presents the word, its op_code field and its address to
// the decoder. When the issued instruction is consumed, the unit computes the
// next PC from the branch controls, the ALU Zero flag and the word offset.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (wins over every other input)
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address (always equal to pc)
//   imem_ready   memory returns imem_rdata this cycle; completes the request
//   imem_rdata   instruction word, sampled on FETCH & imem_ready
//   stall        downstream not ready; holds the issued instruction
//   Branch       conditional branch (CBZ) from the control decoder
//   UnconBranch  unconditional branch (B) from the control decoder
//   Zero         ALU zero flag of the issued instruction
//   br_offset    sign-extended word offset of the issued instruction
//   instr_valid  instr / op_code / pc hold a valid issued instruction
//   instr        issued instruction word
//   op_code      instr[31:21]
//   pc           address of the issued instruction
//
// All outputs come from registers, so there is no combinational path from an
// input to an output.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               Branch,
    input  logic               UnconBranch,
    input  logic               Zero,
    input  logic [ADDR_W-1:0]  br_offset,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [10:0]        op_code,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t               state_r;
    state_t               state_next_s;
    logic                 imem_req_r;
    logic                 instr_valid_r;
    logic [INSTR_W-1:0]   instr_r;
    logic [10:0]          op_code_r;
    logic [ADDR_W-1:0]    pc_r;

    logic                 fetch_done_s;
    logic                 consume_s;
    logic                 taken_s;
    logic [ADDR_W-1:0]    next_pc_s;

    // Selects the next PC. Relative branches scale the word offset to a byte
    // offset, and the add wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] cur_pc,
        input logic [ADDR_W-1:0] word_offset,
        input logic              take
    );
        logic [ADDR_W-1:0] byte_offset;
        byte_offset = word_offset << 2'd2;
        if (take) begin
            calc_next_pc = cur_pc + byte_offset;
        end else begin
            calc_next_pc = cur_pc + PC_STEP;
        end
    endfunction

    // Decodes the handshake events and the branch decision. The branch
    // inputs only matter on the consume edge.
    always_comb begin
        fetch_done_s = (state_r == ST_FETCH) && imem_ready;
        consume_s    = (state_r == ST_ISSUE) && !stall;
        taken_s      = UnconBranch | (Branch & Zero);
        next_pc_s    = calc_next_pc(pc_r, br_offset, taken_s);
    end

    // Computes the next state. IDLE is left after exactly one cycle. An
    // unreachable encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Holds the state register. The request and valid flags are registered
    // from the next state, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            imem_req_r    <= (state_next_s == ST_FETCH);
            instr_valid_r <= (state_next_s == ST_ISSUE);
        end
    end

    // Captures the fetched word and advances the PC on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r   <= '0;
            op_code_r <= 11'd0;
            pc_r      <= RESET_PC;
        end else begin
            if (fetch_done_s) begin
                instr_r   <= imem_rdata;
                op_code_r <= imem_rdata[INSTR_W-1 -: 11];
            end
            if (consume_s) begin
                pc_r <= next_pc_s;
            end
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign op_code     = op_code_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Two instances share all inputs: dut_a resets to PC 0, and dut_w resets to
// 2^64-4. Because every PC update is relative, dut_w's PC always equals
// dut_a's PC minus 4 modulo 2^64. This lets one stimulus stream also exercise
// the wrap-around.
//
// The reference model is transaction level. Each fetched instruction is a
// number of wait cycles, a number of stall cycles and a consume carrying
// branch controls. The expected PC follows the architectural rule:
// pc + 4*offset if taken, otherwise pc + 4.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [63:0] RST_W = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Branch;
    logic        UnconBranch;
    logic        Zero;
    logic [63:0] br_offset;

    logic        req_a, valid_a, req_w, valid_w;
    logic [63:0] addr_a, pc_a, addr_w, pc_w;
    logic [31:0] instr_a, instr_w;
    logic [10:0] op_a, op_w;

    int checks = 0;
    int errors = 0;

    longint unsigned exp_pc;
    logic [31:0]     exp_instr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'd0)) dut_a (
        .clk(clk), .reset(reset),
        .imem_req(req_a), .imem_addr(addr_a),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .Branch(Branch), .UnconBranch(UnconBranch),
        .Zero(Zero), .br_offset(br_offset),
        .instr_valid(valid_a), .instr(instr_a), .op_code(op_a), .pc(pc_a)
    );

    instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(RST_W)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .Branch(Branch), .UnconBranch(UnconBranch),
        .Zero(Zero), .br_offset(br_offset),
        .instr_valid(valid_w), .instr(instr_w), .op_code(op_w), .pc(pc_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Randomizes the inputs that must be ignored in the current phase.
    task automatic scramble_ignored();
        stall       = 1'($urandom);
        Branch      = 1'($urandom);
        UnconBranch = 1'($urandom);
        Zero        = 1'($urandom);
        br_offset   = {$urandom, $urandom};
    endtask

    // Checks both instances while a request is outstanding.
    task automatic check_fetch(input string tag);
        chk({tag, "_req"},   64'(req_a),   64'd1);
        chk({tag, "_valid"}, 64'(valid_a), 64'd0);
        chk({tag, "_addr"},  addr_a,       exp_pc);
        chk({tag, "_reqw"},  64'(req_w),   64'd1);
        chk({tag, "_addrw"}, addr_w,       exp_pc - 64'd4);
    endtask

    // Checks both instances while an instruction is issued.
    task automatic check_issue(input string tag);
        chk({tag, "_req"},   64'(req_a),   64'd0);
        chk({tag, "_valid"}, 64'(valid_a), 64'd1);
        chk({tag, "_instr"}, 64'(instr_a), 64'(exp_instr));
        chk({tag, "_op"},    64'(op_a),    64'(exp_instr >> 21));
        chk({tag, "_pc"},    pc_a,         exp_pc);
        chk({tag, "_validw"}, 64'(valid_w), 64'd1);
        chk({tag, "_opw"},   64'(op_w),    64'(exp_instr >> 21));
        chk({tag, "_pcw"},   pc_w,         exp_pc - 64'd4);
    endtask

    // One complete instruction transaction. It is entered with the DUT in
    // FETCH and returns with the DUT back in FETCH at the model's new PC.
    task automatic do_instr(input int waits, input int stalls, input logic br,
                            input logic ub, input logic z,
                            input logic [63:0] off, input logic [31:0] word);
        logic taken;
        for (int i = 0; i < waits; i++) begin
            check_fetch("wait");
            scramble_ignored();
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            step();
        end
        check_fetch("fetch");
        scramble_ignored();
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        exp_instr = word;
        for (int s = 0; s < stalls; s++) begin
            check_issue("stall");
            scramble_ignored();
            stall      = 1'b1;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            step();
        end
        check_issue("issue");
        stall       = 1'b0;
        Branch      = br;
        UnconBranch = ub;
        Zero        = z;
        br_offset   = off;
        imem_ready  = 1'($urandom);
        imem_rdata  = $urandom;
        step();
        taken  = ub | (br & z);
        exp_pc = taken ? exp_pc + (off * 64'd4) : exp_pc + 64'd4;
        imem_ready = 1'b0;
    endtask

    // Runs a reset sequence and checks the reset state of both instances.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        chk("rst_req",   64'(req_a),   64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_addr",  addr_a,       64'd0);
        chk("rst_instr", 64'(instr_a), 64'd0);
        chk("rst_op",    64'(op_a),    64'd0);
        chk("rst_reqw",  64'(req_w),   64'd0);
        chk("rst_valw",  64'(valid_w), 64'd0);
        chk("rst_addrw", addr_w,       RST_W);
        reset = 1'b0;
        imem_ready = 1'b1;
        step();
        exp_pc = 64'd0;
        imem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        Branch = 1'b0; UnconBranch = 1'b0; Zero = 1'b0; br_offset = 64'd0;
        exp_pc = 64'd0; exp_instr = 32'd0;

        do_reset(2);

        // ADD at pc 0; fall through to 4.
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 32'h8B02_0020);
        chk("add_op_lit", 64'(op_a), 64'h458);
        chk("add_next",   addr_a,    64'h4);
        // The wrapped instance must have wrapped to 0.
        chk("wrap_addr",  addr_w,    64'h0);

        // Three wait states, then fall through to 8.
        do_instr(3, 0, 1'b0, 1'b0, 1'b0, 64'd0, 32'hF840_0001);
        chk("wait_next", addr_a, 64'h8);

        // CBZ taken at 8, offset 3.
        do_instr(0, 1, 1'b1, 1'b0, 1'b1, 64'd3, 32'hB400_0060);
        chk("cbz_taken", addr_a, 64'h14);
        // Branch back to 8 with offset -3.
        do_instr(1, 0, 1'b0, 1'b1, 1'b0, -64'sd3, 32'h17FF_FFFD);
        chk("b_back", addr_a, 64'h8);
        // CBZ not taken.
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 64'd3, 32'hB400_0060);
        chk("cbz_nt", addr_a, 64'hC);
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'd7, 32'h8B02_0020);
        // B at 0x10, offset -2.
        do_instr(0, 4, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h17FF_FFFE);
        chk("b_neg", addr_a, 64'h8);
        // Zero without any branch does not redirect.
        do_instr(0, 0, 1'b0, 1'b0, 1'b1, 64'd5, 32'h8B02_0020);
        chk("zero_only", addr_a, 64'hC);
        // Branch and UnconBranch together are taken.
        do_instr(0, 0, 1'b1, 1'b1, 1'b0, 64'd2, 32'h1400_0002);
        chk("both_taken", addr_a, 64'h14);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            logic [63:0] off;
            if ($urandom_range(0, 7) == 0) off = {$urandom, $urandom};
            else off = 64'(longint'($urandom_range(0, 127)) - 64);
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                     1'($urandom), 1'($urandom), off, $urandom);
        end

        // Reset mid-FETCH, with a late ready on the reset edge.
        check_fetch("pre_rst");
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        do_reset(1);
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 32'h8B02_0020);

        // Reset mid-ISSUE.
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        exp_instr = 32'h1234_5678;
        check_issue("pre_rst2");
        stall = 1'b0;
        do_reset(1);
        check_fetch("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
